// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache lookup/refill path: controller state
// encoding, address-slicing widths and one-hot/priority-encode functions.
package cache_pkg;

   localparam logic RstEnable = 1'b1;
   localparam int unsigned MAX_WAYS = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOOKUP   = 3'd1,
      ST_MISS_REQ = 3'd2,
      ST_REFILL   = 3'd3,
      ST_DONE     = 3'd4
   } refill_state_t;

   function automatic int unsigned word_sel_w(input int unsigned line_words);
      return $clog2(line_words);
   endfunction

   // Bit position of the tag LSB in a byte address (index + word select + byte).
   function automatic int unsigned tag_lsb(input int unsigned index_w,
                                           input int unsigned line_words);
      return index_w + $clog2(line_words) + 2;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      logic [3:0] vec;
      case (idx)
         2'd0:    vec = 4'b0001;
         2'd1:    vec = 4'b0010;
         2'd2:    vec = 4'b0100;
         2'd3:    vec = 4'b1000;
         default: vec = 4'b0000;
      endcase
      return vec;
   endfunction

   // Lowest set bit wins, so an illegal multi-hit still resolves deterministically.
   function automatic logic [1:0] encode(input logic [3:0] vec);
      logic [1:0] idx;
      if (vec[0]) begin
         idx = 2'd0;
      end else if (vec[1]) begin
         idx = 2'd1;
      end else if (vec[2]) begin
         idx = 2'd2;
      end else if (vec[3]) begin
         idx = 2'd3;
      end else begin
         idx = 2'd0;
      end
      return idx;
   endfunction

endpackage

// File: rtl/tag_compare.sv
// Combinational tag match: per-way hit vector plus priority-encoded hit way.
module tag_compare
   import cache_pkg::*;
#(
   parameter int ASSOC_NUM = 4,
   parameter int TAG_W     = 20
) (
   input  logic [ASSOC_NUM*TAG_W-1:0]   tag_rdata,
   input  logic [ASSOC_NUM-1:0]         tag_rvalid,
   input  logic [TAG_W-1:0]             tag,
   output logic [ASSOC_NUM-1:0]         hit_vec,
   output logic                         hit,
   output logic [$clog2(ASSOC_NUM)-1:0] hit_way
);

   localparam int WAY_W = $clog2(ASSOC_NUM);

   logic [3:0] hit_pad_s;
   logic [1:0] hit_enc_s;

   // Per-way valid-and-equal compare
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < ASSOC_NUM; i++) begin
         hit_vec[i] = tag_rvalid[i] && (tag_rdata[i*TAG_W +: TAG_W] == tag);
      end
   end

   // Pad to the package width and priority-encode
   always_comb begin
      hit_pad_s                = 4'b0000;
      hit_pad_s[ASSOC_NUM-1:0] = hit_vec;
      hit_enc_s                = encode(hit_pad_s);
      hit_way                  = hit_enc_s[WAY_W-1:0];
      hit                      = |hit_vec;
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache lookup/refill controller: tag compare, PLRU update, single-burst line refill.
// Optional hit/miss performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int ASSOC_NUM  = 4,
   parameter int LINE_WORDS = 8,
   parameter int INDEX_W    = 7,
   parameter int TAG_W      = 20
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [31:0]                   req_addr,
   input  logic [ASSOC_NUM*TAG_W-1:0]    tag_rdata,
   input  logic [ASSOC_NUM-1:0]          tag_rvalid,
   output logic [ASSOC_NUM-1:0]          plru_access,
   output logic                          plru_update,
   input  logic [$clog2(ASSOC_NUM)-1:0]  plru_lru,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic [31:0]                   mem_req_addr,
   input  logic                          mem_rvalid,
   input  logic [31:0]                   mem_rdata,
   input  logic                          mem_rlast,
   output logic [ASSOC_NUM-1:0]          line_we,
   output logic [INDEX_W-1:0]            line_index,
   output logic [$clog2(LINE_WORDS)-1:0] line_offset,
   output logic [31:0]                   line_wdata,
   output logic [ASSOC_NUM-1:0]          tag_we,
   output logic [TAG_W-1:0]              tag_wdata,
   output logic                          resp_valid,
   output logic                          resp_hit,
   output logic [$clog2(ASSOC_NUM)-1:0]  resp_way
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0]                   perf_hit_cnt,
   output logic [31:0]                   perf_miss_cnt
`endif
);

   localparam int WAY_W   = $clog2(ASSOC_NUM);
   localparam int WSEL_W  = word_sel_w(LINE_WORDS);
   localparam int TAG_LSB = tag_lsb(INDEX_W, LINE_WORDS);

   refill_state_t       state_q, state_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [INDEX_W-1:0]  index_q, index_d;
   logic [WAY_W-1:0]    victim_q, victim_d;
   logic [WSEL_W-1:0]   beat_cnt_q, beat_cnt_d;

   logic [ASSOC_NUM-1:0] hit_vec_s;
   logic                 hit_s;
   logic [WAY_W-1:0]     hit_way_s;
   logic [3:0]           victim_oh4_s;
   logic [ASSOC_NUM-1:0] victim_oh_s;

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
`endif

   tag_compare #(
      .ASSOC_NUM (ASSOC_NUM),
      .TAG_W     (TAG_W)
   ) u_tag_compare (
      .tag_rdata  (tag_rdata),
      .tag_rvalid (tag_rvalid),
      .tag        (tag_q),
      .hit_vec    (hit_vec_s),
      .hit        (hit_s),
      .hit_way    (hit_way_s)
   );

   // Victim way as a one-hot vector of the configured width
   always_comb begin
      victim_oh4_s = onehot(2'(victim_q));
      victim_oh_s  = victim_oh4_s[ASSOC_NUM-1:0];
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d    = state_q;
      tag_d      = tag_q;
      index_d    = index_q;
      victim_d   = victim_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               tag_d   = req_addr[31 -: TAG_W];
               index_d = req_addr[TAG_LSB-1 -: INDEX_W];
               state_d = ST_LOOKUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            if (hit_s) begin
               state_d = ST_IDLE;
            end else begin
               victim_d = plru_lru;
               state_d  = ST_MISS_REQ;
            end
         end
         ST_MISS_REQ: begin
            if (mem_req_ready) begin
               beat_cnt_d = '0;
               state_d    = ST_REFILL;
            end else begin
               state_d = ST_MISS_REQ;
            end
         end
         ST_REFILL: begin
            if (mem_rvalid) begin
               beat_cnt_d = beat_cnt_q + WSEL_W'(1);
               if (mem_rlast) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_REFILL;
               end
            end else begin
               state_d = ST_REFILL;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef CACHE_PERF_CNT_EN
   // Saturating hit/miss counters, stepped in the LOOKUP cycle
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == ST_LOOKUP) begin
         if (hit_s) begin
            if (hit_cnt_q != 32'hFFFF_FFFF) begin
               hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
               hit_cnt_d = hit_cnt_q;
            end
         end else begin
            if (miss_cnt_q != 32'hFFFF_FFFF) begin
               miss_cnt_d = miss_cnt_q + 32'd1;
            end else begin
               miss_cnt_d = miss_cnt_q;
            end
         end
      end else begin
         hit_cnt_d  = hit_cnt_q;
         miss_cnt_d = miss_cnt_q;
      end
   end

   assign perf_hit_cnt  = hit_cnt_q;
   assign perf_miss_cnt = miss_cnt_q;
`endif

   // Output decode from state; data outputs are zeroed unless their strobe is live
   always_comb begin
      req_ready     = 1'b0;
      plru_access   = '0;
      plru_update   = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = 32'd0;
      line_we       = '0;
      line_index    = '0;
      line_offset   = '0;
      line_wdata    = 32'd0;
      tag_we        = '0;
      tag_wdata     = '0;
      resp_valid    = 1'b0;
      resp_hit      = 1'b0;
      resp_way      = '0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
         end
         ST_LOOKUP: begin
            if (hit_s) begin
               plru_access = hit_vec_s;
               plru_update = 1'b1;
               resp_valid  = 1'b1;
               resp_hit    = 1'b1;
               resp_way    = hit_way_s;
            end else begin
               plru_update = 1'b0;
            end
         end
         ST_MISS_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {tag_q, index_q, {(TAG_LSB-INDEX_W){1'b0}}};
         end
         ST_REFILL: begin
            if (mem_rvalid) begin
               line_we     = victim_oh_s;
               line_index  = index_q;
               line_offset = beat_cnt_q;
               line_wdata  = mem_rdata;
               if (mem_rlast) begin
                  tag_we    = victim_oh_s;
                  tag_wdata = tag_q;
               end else begin
                  tag_we = '0;
               end
            end else begin
               line_we = '0;
            end
         end
         ST_DONE: begin
            plru_access = victim_oh_s;
            plru_update = 1'b1;
            resp_valid  = 1'b1;
            resp_hit    = 1'b0;
            resp_way    = victim_q;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any refill in flight
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn == RstEnable) begin
         state_q    <= ST_IDLE;
         tag_q      <= '0;
         index_q    <= '0;
         victim_q   <= '0;
         beat_cnt_q <= '0;
`ifdef CACHE_PERF_CNT_EN
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
`endif
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         index_q    <= index_d;
         victim_q   <= victim_d;
         beat_cnt_q <= beat_cnt_d;
`ifdef CACHE_PERF_CNT_EN
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
`endif
      end
   end

endmodule
